gpio_in_cond: RTL and testbench

Per-pin input conditioning and interrupt generation for the GPIO block. Takes the already-synchronized input bits produced by the per-pin GPIO pad logic, applies an optional per-pin debounce filter, and detects rising, falling and level events into sticky, maskable interrupt status bits. Sits between the pad bits and the GPIO register interface. Drives the filtered input data register and the GPIO interrupt line.

---
 rtl/gpio_in_cond_if.sv | 49 ++++
 rtl/gpio_in_cond.sv | 90 +++++++++
 tb/tb_gpio_in_cond.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gpio_in_cond_if.sv
// -----------------------------------------------------------------------------
// gpio_in_cond_if
//   Bundle of the pad-side, register-side and interrupt signals around the
//   GPIO input conditioning block.
//   master : register/pad side (drives pins, config, clear strobe; reads
//            filtered data, status and irq)
//   slave  : gpio_in_cond itself
//   Signals:
//     i_sync         synchronized pin inputs
//     debounce_en    per-pin debounce enable (0 = bypass)
//     debounce_limit consecutive differing samples needed to accept a change
//     rise_en/fall_en/level_en  per-pin event enables
//     level_pol      active level for level events (1 = high)
//     irq_mask       per-pin interrupt enable
//     clr_valid/clr_mask  write-1-to-clear strobe and bit mask
//     data_in        filtered pin values
//     irq_status     sticky event status
//     irq            OR of unmasked status bits
// -----------------------------------------------------------------------------
interface gpio_in_cond_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  logic [WIDTH-1:0] i_sync;
  logic [WIDTH-1:0] debounce_en;
  logic [CNT_W-1:0] debounce_limit;
  logic [WIDTH-1:0] rise_en;
  logic [WIDTH-1:0] fall_en;
  logic [WIDTH-1:0] level_en;
  logic [WIDTH-1:0] level_pol;
  logic [WIDTH-1:0] irq_mask;
  logic             clr_valid;
  logic [WIDTH-1:0] clr_mask;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] irq_status;
  logic             irq;

  modport master (
    output i_sync, debounce_en, debounce_limit, rise_en, fall_en,
           level_en, level_pol, irq_mask, clr_valid, clr_mask,
    input  data_in, irq_status, irq
  );

  modport slave (
    input  i_sync, debounce_en, debounce_limit, rise_en, fall_en,
           level_en, level_pol, irq_mask, clr_valid, clr_mask,
    output data_in, irq_status, irq
  );
endinterface

// File: rtl/gpio_in_cond.sv
// -----------------------------------------------------------------------------
// gpio_in_cond
//   Per-pin input conditioning for the GPIO block: optional debounce filter on
//   the already-synchronized pad bits, then rising/falling/level event
//   detection into sticky, write-1-to-clear, maskable interrupt status.
//   Ports:
//     clk      block clock, rising edge
//     reset_n  asynchronous active-low reset
//     bus      gpio_in_cond_if.slave (pins, config, clear strobe, data_in,
//              irq_status, irq)
// -----------------------------------------------------------------------------
module gpio_in_cond #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic           clk,
  input  logic           reset_n,
  gpio_in_cond_if.slave  bus
);

  logic [WIDTH-1:0] r_f;
  logic [WIDTH-1:0] r_status;
  logic [CNT_W-1:0] r_cnt [WIDTH];

  logic [CNT_W-1:0] w_dbl_m1;
  logic [CNT_W-1:0] w_lim_m1   [WIDTH];
  logic [CNT_W-1:0] w_cnt_next [WIDTH];
  logic [WIDTH-1:0] w_f_next;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_level;
  logic [WIDTH-1:0] w_set;
  logic [WIDTH-1:0] w_clr;

  // Limit 0 behaves as 1, so the compare threshold (L-1) never underflows.
  assign w_dbl_m1 = (bus.debounce_limit == '0) ? '0 : bus.debounce_limit - 1'b1;

  // NOTE: every variable gets a default at the top of the block so no path
  // leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    for (int b = 0; b < WIDTH; b++) begin
      w_lim_m1[b]   = bus.debounce_en[b] ? w_dbl_m1 : '0;
      w_f_next[b]   = r_f[b];
      w_cnt_next[b] = '0;
      if (bus.i_sync[b] != r_f[b]) begin
        // The >= compare matters when the limit shrinks mid-count: an
        // already-long enough run is accepted at once instead of wrapping.
        if (r_cnt[b] >= w_lim_m1[b]) begin
          w_f_next[b] = bus.i_sync[b];
        end else begin
          w_cnt_next[b] = r_cnt[b] + 1'b1;
        end
      end
    end
  end

  // Edges look at the value f takes at this edge so status lands in the same
  // cycle data_in changes; level looks at the current filtered value.
  assign w_rise  = bus.rise_en  & ~r_f &  w_f_next;
  assign w_fall  = bus.fall_en  &  r_f & ~w_f_next;
  assign w_level = bus.level_en & ~(r_f ^ bus.level_pol);
  assign w_set   = w_rise | w_fall | w_level;
  assign w_clr   = {WIDTH{bus.clr_valid}} & bus.clr_mask;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  // NOTE: the counter array is a set of ordinary flops, not a RAM, so it is
  // reset along with everything else; no stale count survives a reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_f      <= '0;
      r_status <= '0;
      for (int b = 0; b < WIDTH; b++) begin
        r_cnt[b] <= '0;
      end
    end else begin
      r_f      <= w_f_next;
      // Set wins over a same-cycle clear.
      r_status <= w_set | (r_status & ~w_clr);
      for (int b = 0; b < WIDTH; b++) begin
        r_cnt[b] <= w_cnt_next[b];
      end
    end
  end

  assign bus.data_in    = r_f;
  assign bus.irq_status = r_status;
  assign bus.irq        = |(r_status & bus.irq_mask);

endmodule

// File: tb/tb_gpio_in_cond.sv
module tb_gpio_in_cond;
  localparam int WIDTH = 8;
  localparam int CNT_W = 16;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;

  gpio_in_cond_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  gpio_in_cond #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: filtered value, length of the current run of samples
  // that disagree with it, and sticky status.
  bit [WIDTH-1:0] m_f;
  bit [WIDTH-1:0] m_stat;
  int             m_run [WIDTH];

  function automatic void model_reset();
    m_f    = '0;
    m_stat = '0;
    for (int b = 0; b < WIDTH; b++) m_run[b] = 0;
  endfunction

  task automatic init_inputs();
    bus.i_sync         = '0;
    bus.debounce_en    = '0;
    bus.debounce_limit = '0;
    bus.rise_en        = '0;
    bus.fall_en        = '0;
    bus.level_en       = '0;
    bus.level_pol      = '0;
    bus.irq_mask       = '0;
    bus.clr_valid      = 1'b0;
    bus.clr_mask       = '0;
  endtask

  // One clock edge; the model sees the same inputs as the DUT. Returns #1
  // after the edge, where outputs are compared.
  task automatic step();
    bit [WIDTH-1:0] f_next;
    bit [WIDTH-1:0] set_v;
    bit [WIDTH-1:0] clr_v;
    int lim;
    f_next = m_f;
    for (int b = 0; b < WIDTH; b++) begin
      lim = (bus.debounce_en[b] && bus.debounce_limit != 0) ? int'(bus.debounce_limit) : 1;
      if (bus.i_sync[b] == m_f[b]) begin
        m_run[b] = 0;
      end else begin
        m_run[b] = m_run[b] + 1;
        if (m_run[b] >= lim) begin
          f_next[b] = bus.i_sync[b];
          m_run[b]  = 0;
        end
      end
    end
    set_v = (bus.rise_en & ~m_f & f_next) | (bus.fall_en & m_f & ~f_next)
          | (bus.level_en & ~(m_f ^ bus.level_pol));
    clr_v = bus.clr_valid ? bus.clr_mask : '0;
    @(posedge clk);
    #1;
    if (!reset_n) begin
      model_reset();
    end else begin
      m_f    = f_next;
      m_stat = set_v | (m_stat & ~clr_v);
    end
  endtask

  task automatic reset_dut();
    reset_n = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    init_inputs();
    bus.i_sync   = 8'hFF;
    bus.rise_en  = 8'hFF;
    bus.irq_mask = 8'hFF;
    reset_n = 1'b0;
    model_reset();
    #2;
    checks++;
    if (bus.data_in !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", bus.data_in); end
    checks++;
    if (bus.irq_status !== 8'h00) begin errors++; $display("FAIL reset_status got %h want 00", bus.irq_status); end
    checks++;
    if (bus.irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b want 0", bus.irq); end
    step();
    checks++;
    if (bus.irq_status !== 8'h00) begin errors++; $display("FAIL reset_hold_status got %h want 00", bus.irq_status); end
  endtask

  task automatic test_bypass();
    init_inputs();
    reset_dut();
    bus.rise_en  = 8'h01;
    bus.irq_mask = 8'h01;
    bus.i_sync   = 8'h01;
    step();
    checks++;
    if (bus.data_in[0] !== 1'b1) begin errors++; $display("FAIL bypass_data got %b want 1", bus.data_in[0]); end
    checks++;
    if (bus.irq_status !== 8'h01) begin errors++; $display("FAIL bypass_status got %h want 01", bus.irq_status); end
    checks++;
    if (bus.irq !== 1'b1) begin errors++; $display("FAIL bypass_irq got %b want 1", bus.irq); end
    bus.clr_valid = 1'b1;
    bus.clr_mask  = 8'h01;
    step();
    bus.clr_valid = 1'b0;
    checks++;
    if (bus.irq_status !== 8'h00) begin errors++; $display("FAIL bypass_clr_status got %h want 00", bus.irq_status); end
    checks++;
    if (bus.irq !== 1'b0) begin errors++; $display("FAIL bypass_clr_irq got %b want 0", bus.irq); end
  endtask

  task automatic test_debounce();
    init_inputs();
    reset_dut();
    bus.debounce_en    = 8'h08;
    bus.debounce_limit = 16'd4;
    bus.fall_en        = 8'h08;
    bus.i_sync         = 8'h08;
    repeat (4) step();
    checks++;
    if (bus.data_in[3] !== 1'b1) begin errors++; $display("FAIL deb_init got %b want 1", bus.data_in[3]); end
    // 3-sample glitch must be rejected.
    bus.i_sync = 8'h00;
    repeat (3) step();
    bus.i_sync = 8'h08;
    step();
    checks++;
    if (bus.data_in[3] !== 1'b1) begin errors++; $display("FAIL deb_glitch_data got %b want 1", bus.data_in[3]); end
    checks++;
    if (bus.irq_status[3] !== 1'b0) begin errors++; $display("FAIL deb_glitch_status got %b want 0", bus.irq_status[3]); end
    // 4-sample low is accepted on the 4th sample.
    bus.i_sync = 8'h00;
    repeat (3) step();
    checks++;
    if (bus.data_in[3] !== 1'b1) begin errors++; $display("FAIL deb_3rd_data got %b want 1", bus.data_in[3]); end
    step();
    checks++;
    if (bus.data_in[3] !== 1'b0) begin errors++; $display("FAIL deb_4th_data got %b want 0", bus.data_in[3]); end
    checks++;
    if (bus.irq_status[3] !== 1'b1) begin errors++; $display("FAIL deb_4th_status got %b want 1", bus.irq_status[3]); end
  endtask

  task automatic test_level();
    init_inputs();
    reset_dut();
    bus.level_en  = 8'h04;
    bus.level_pol = 8'h00;
    step();
    checks++;
    if (bus.irq_status[2] !== 1'b1) begin errors++; $display("FAIL level_set got %b want 1", bus.irq_status[2]); end
    bus.clr_valid = 1'b1;
    bus.clr_mask  = 8'h04;
    step();
    bus.clr_valid = 1'b0;
    checks++;
    if (bus.irq_status[2] !== 1'b1) begin errors++; $display("FAIL level_reassert got %b want 1", bus.irq_status[2]); end
    checks++;
    if (bus.irq !== 1'b0) begin errors++; $display("FAIL level_masked_irq got %b want 0", bus.irq); end
    bus.i_sync = 8'h04;
    repeat (2) step();
    bus.clr_valid = 1'b1;
    step();
    bus.clr_valid = 1'b0;
    checks++;
    if (bus.irq_status[2] !== 1'b0) begin errors++; $display("FAIL level_inactive_clr got %b want 0", bus.irq_status[2]); end
  endtask

  task automatic test_collision();
    init_inputs();
    reset_dut();
    bus.rise_en = 8'h22;
    bus.i_sync  = 8'h02;
    step();
    checks++;
    if (bus.irq_status !== 8'h02) begin errors++; $display("FAIL coll_pre got %h want 02", bus.irq_status); end
    bus.i_sync    = 8'h22;
    bus.clr_valid = 1'b1;
    bus.clr_mask  = 8'hFF;
    step();
    bus.clr_valid = 1'b0;
    checks++;
    if (bus.irq_status !== 8'h20) begin errors++; $display("FAIL coll_status got %h want 20", bus.irq_status); end
  endtask

  task automatic test_mask_limit0();
    init_inputs();
    reset_dut();
    bus.debounce_en    = 8'h80;
    bus.debounce_limit = 16'd0;
    bus.rise_en        = 8'h80;
    bus.i_sync         = 8'h80;
    step();
    checks++;
    if (bus.data_in[7] !== 1'b1) begin errors++; $display("FAIL mask_data got %b want 1", bus.data_in[7]); end
    checks++;
    if (bus.irq_status[7] !== 1'b1) begin errors++; $display("FAIL mask_status got %b want 1", bus.irq_status[7]); end
    checks++;
    if (bus.irq !== 1'b0) begin errors++; $display("FAIL mask_irq_off got %b want 0", bus.irq); end
    bus.irq_mask = 8'h80;
    #1;
    checks++;
    if (bus.irq !== 1'b1) begin errors++; $display("FAIL mask_irq_on got %b want 1", bus.irq); end
  endtask

  task automatic test_reset_midcount();
    init_inputs();
    bus.i_sync         = 8'h01;
    bus.debounce_en    = 8'h01;
    bus.debounce_limit = 16'd10;
    bus.rise_en        = 8'h01;
    bus.irq_mask       = 8'h01;
    reset_dut();
    repeat (9) step();
    checks++;
    if (bus.irq_status !== 8'h00 || bus.data_in !== 8'h00) begin
      errors++; $display("FAIL rst_cnt9 got st=%h d=%h want 00 00", bus.irq_status, bus.data_in);
    end
    step();
    checks++;
    if (bus.irq_status !== 8'h01 || bus.data_in !== 8'h01) begin
      errors++; $display("FAIL rst_cnt10 got st=%h d=%h want 01 01", bus.irq_status, bus.data_in);
    end
    // Repeat run, interrupted at cycle 5.
    reset_dut();
    repeat (4) step();
    reset_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (bus.irq_status !== 8'h00 || bus.data_in !== 8'h00 || bus.irq !== 1'b0) begin
      errors++; $display("FAIL rst_async got st=%h d=%h irq=%b want 0", bus.irq_status, bus.data_in, bus.irq);
    end
    for (int i = 0; i < 12; i++) begin
      step();
      checks++;
      if (bus.irq_status !== 8'h00 || bus.data_in !== 8'h00 || bus.irq !== 1'b0) begin
        errors++; $display("FAIL rst_hold%0d got st=%h d=%h irq=%b want 0", i, bus.irq_status, bus.data_in, bus.irq);
      end
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (9) step();
    checks++;
    if (bus.irq_status !== 8'h00) begin errors++; $display("FAIL rst_rerun9 got %h want 00", bus.irq_status); end
    step();
    checks++;
    if (bus.irq_status !== 8'h01) begin errors++; $display("FAIL rst_rerun10 got %h want 01", bus.irq_status); end
  endtask

  task automatic test_random();
    bit exp_irq;
    init_inputs();
    reset_dut();
    for (int i = 0; i < 3000; i++) begin
      if (i % 64 == 0) begin
        bus.debounce_en = WIDTH'($urandom);
        bus.rise_en     = WIDTH'($urandom);
        bus.fall_en     = WIDTH'($urandom);
        bus.level_en    = WIDTH'($urandom) & WIDTH'($urandom);
        bus.level_pol   = WIDTH'($urandom);
      end
      if ($urandom_range(0, 31) == 0) bus.debounce_limit = CNT_W'($urandom_range(0, 5));
      if ($urandom_range(0, 15) == 0) bus.irq_mask = WIDTH'($urandom);
      for (int b = 0; b < WIDTH; b++) begin
        if ($urandom_range(0, 3) == 0) bus.i_sync[b] = ~bus.i_sync[b];
      end
      bus.clr_valid = ($urandom_range(0, 5) == 0);
      bus.clr_mask  = WIDTH'($urandom);
      if (i == 1500) reset_n = 1'b0;
      if (i == 1503) reset_n = 1'b1;
      step();
      exp_irq = |(m_stat & bus.irq_mask);
      checks++;
      if (bus.data_in !== m_f) begin errors++; $display("FAIL rnd_data@%0d got %h want %h", i, bus.data_in, m_f); end
      checks++;
      if (bus.irq_status !== m_stat) begin errors++; $display("FAIL rnd_status@%0d got %h want %h", i, bus.irq_status, m_stat); end
      checks++;
      if (bus.irq !== exp_irq) begin errors++; $display("FAIL rnd_irq@%0d got %b want %b", i, bus.irq, exp_irq); end
    end
    bus.clr_valid = 1'b0;
  endtask

  initial begin
    init_inputs();
    model_reset();
    test_reset();
    test_bypass();
    test_debounce();
    test_level();
    test_collision();
    test_mask_limit0();
    test_reset_midcount();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
